// File: rtl/mm_seq_ctrl_if.sv
// Signal bundle shared by the MM sequencer, the element stream source and
// the MM datapath (operand buffers + MAC). The master side is the
// source/datapath environment; the slave side is the sequencer itself.
interface mm_seq_ctrl_if #(
  parameter int ADDR_W = 8
);
  // element stream from the source
  logic              in_valid;
  logic              col_end;
  logic              row_end;
  logic              busy;
  // operand buffer write port
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  // operand buffer read port and MAC controls
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              mac_en;
  logic              mac_clr;
  logic              mac_last;
  // result status, aligned with the datapath result
  logic              out_valid;
  logic              is_legal;
  logic              change_row;

  modport master (
    output in_valid, col_end, row_end,
    input  busy, wr_en, wr_sel, wr_addr, rd_addr_a, rd_addr_b,
    input  mac_en, mac_clr, mac_last, out_valid, is_legal, change_row
  );

  modport slave (
    input  in_valid, col_end, row_end,
    output busy, wr_en, wr_sel, wr_addr, rd_addr_a, rd_addr_b,
    output mac_en, mac_clr, mac_last, out_valid, is_legal, change_row
  );
endinterface

// File: rtl/mm_seq_ctrl.sv
// MM matrix-multiply sequencer.
// Captures the raster-order A and B element streams into the operand
// buffers while measuring both shapes, checks conformability, then walks
// every dot product one term per cycle (k innermost) and flags each
// result PIPE cycles after its last term. Read addresses are produced by
// incremental adds only. wr_* are combinational from the stream; every
// other output is a flop.
module mm_seq_ctrl #(
  parameter int DIM_W  = 4,
  parameter int ADDR_W = 8,
  parameter int PIPE   = 2
) (
  input  logic         clk,
  input  logic         rst,
  mm_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    CHECK   = 3'd3,
    COMPUTE = 3'd4,
    DRAIN   = 3'd5,
    REJECT  = 3'd6
  } state_t;

  // counts carry one extra bit so an oversize row/column is still visible
  localparam logic [DIM_W:0]    DIM_MAX_C = {1'b0, {DIM_W{1'b1}}};
  localparam logic [DIM_W:0]    DIM_SAT_C = {1'b1, {DIM_W{1'b0}}};
  localparam logic [DIM_W:0]    E_ONE_C   = (DIM_W+1)'(1'b1);
  localparam logic [DIM_W-1:0]  D_ONE_C   = DIM_W'(1'b1);
  localparam logic [ADDR_W-1:0] A_ONE_C   = ADDR_W'(1'b1);
  localparam logic [7:0]        DRAIN_END_C = 8'(PIPE - 1);
  localparam logic [7:0]        B_ONE_C   = 8'(1'b1);
  localparam int                DLY_N     = (PIPE > 1) ? PIPE - 1 : 1;

  // saturate a running count just above the largest legal dimension
  function automatic logic [DIM_W:0] sat_cnt(input logic [DIM_W:0] v);
    return (v > DIM_SAT_C) ? DIM_SAT_C : v;
  endfunction

  state_t            state_r;
  logic [ADDR_W-1:0] elem_cnt_r;
  logic [DIM_W:0]    col_cnt_r;
  logic [DIM_W:0]    row_cnt_r;
  logic [DIM_W:0]    first_len_r;
  logic              first_done_r;
  logic              bad_r;
  logic [DIM_W-1:0]  a_rows_r;
  logic [DIM_W-1:0]  a_cols_r;
  logic [DIM_W-1:0]  b_rows_r;
  logic [DIM_W-1:0]  b_cols_r;
  logic [DIM_W-1:0]  i_r;
  logic [DIM_W-1:0]  j_r;
  logic [DIM_W-1:0]  k_r;
  logic [ADDR_W-1:0] a_base_r;
  logic [7:0]        drain_cnt_r;
  logic [DLY_N-1:0]  vld_sr_r;
  logic [DLY_N-1:0]  row_sr_r;

  logic              busy_r;
  logic [ADDR_W-1:0] rd_addr_a_r;
  logic [ADDR_W-1:0] rd_addr_b_r;
  logic              mac_en_r;
  logic              mac_clr_r;
  logic              mac_last_r;
  logic              out_valid_r;
  logic              is_legal_r;
  logic              change_row_r;

  logic              loading_s;
  logic              take_s;
  logic              eol_s;
  logic [DIM_W:0]    len_s;
  logic [DIM_W:0]    row_nxt_s;
  logic [DIM_W-1:0]  cols_s;
  logic              row_bad_s;
  logic              k_last_s;
  logic              j_last_s;
  logic              i_last_s;
  logic              tap_vld_s;
  logic              tap_row_s;

  // Stream bookkeeping for the element presented this cycle
  always_comb begin
    loading_s = 1'b0;
    case (state_r)
      IDLE, LOAD_A, LOAD_B: loading_s = 1'b1;
      default:              loading_s = 1'b0;
    endcase
    take_s    = loading_s & bus.in_valid;
    // row_end always closes the current row as well
    eol_s     = bus.col_end | bus.row_end;
    len_s     = col_cnt_r + E_ONE_C;
    row_nxt_s = row_cnt_r + E_ONE_C;
    if (first_done_r) begin
      cols_s = first_len_r[DIM_W-1:0];
    end else begin
      cols_s = len_s[DIM_W-1:0];
    end
    if (eol_s) begin
      row_bad_s = (len_s > DIM_MAX_C) | (row_nxt_s > DIM_MAX_C) |
                  (first_done_r & (len_s != first_len_r));
    end else begin
      row_bad_s = 1'b0;
    end
  end

  // Loop-boundary flags for the term currently on the read port
  always_comb begin
    k_last_s = (k_r == (a_cols_r - D_ONE_C));
    j_last_s = (j_r == (b_cols_r - D_ONE_C));
    i_last_s = (i_r == (a_rows_r - D_ONE_C));
    if (PIPE > 1) begin
      tap_vld_s = vld_sr_r[DLY_N-1];
      tap_row_s = row_sr_r[DLY_N-1];
    end else begin
      tap_vld_s = mac_en_r & mac_last_r;
      tap_row_s = mac_en_r & mac_last_r & j_last_s;
    end
  end

  assign bus.wr_en      = take_s;
  assign bus.wr_sel     = (state_r == LOAD_B);
  assign bus.wr_addr    = elem_cnt_r;
  assign bus.busy       = busy_r;
  assign bus.rd_addr_a  = rd_addr_a_r;
  assign bus.rd_addr_b  = rd_addr_b_r;
  assign bus.mac_en     = mac_en_r;
  assign bus.mac_clr    = mac_clr_r;
  assign bus.mac_last   = mac_last_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.is_legal   = is_legal_r;
  assign bus.change_row = change_row_r;

  // Sequencer FSM: stream capture, shape check, term walk and result alignment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      elem_cnt_r   <= '0;
      col_cnt_r    <= '0;
      row_cnt_r    <= '0;
      first_len_r  <= '0;
      first_done_r <= 1'b0;
      bad_r        <= 1'b0;
      a_rows_r     <= '0;
      a_cols_r     <= '0;
      b_rows_r     <= '0;
      b_cols_r     <= '0;
      i_r          <= '0;
      j_r          <= '0;
      k_r          <= '0;
      a_base_r     <= '0;
      drain_cnt_r  <= '0;
      vld_sr_r     <= '0;
      row_sr_r     <= '0;
      busy_r       <= 1'b0;
      rd_addr_a_r  <= '0;
      rd_addr_b_r  <= '0;
      mac_en_r     <= 1'b0;
      mac_clr_r    <= 1'b0;
      mac_last_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      is_legal_r   <= 1'b0;
      change_row_r <= 1'b0;
    end else begin
      // delay line from each mac_last to its datapath result
      vld_sr_r[0] <= mac_en_r & mac_last_r;
      row_sr_r[0] <= mac_en_r & mac_last_r & j_last_s;
      for (int p = 1; p < DLY_N; p++) begin
        vld_sr_r[p] <= vld_sr_r[p-1];
        row_sr_r[p] <= row_sr_r[p-1];
      end
      out_valid_r  <= tap_vld_s;
      is_legal_r   <= tap_vld_s;
      change_row_r <= tap_row_s;

      case (state_r)
        IDLE, LOAD_A, LOAD_B: begin
          if (take_s) begin
            elem_cnt_r <= elem_cnt_r + A_ONE_C;
            if (row_bad_s) begin
              bad_r <= 1'b1;
            end
            if (eol_s) begin
              col_cnt_r <= '0;
              row_cnt_r <= sat_cnt(row_nxt_s);
              if (!first_done_r) begin
                first_done_r <= 1'b1;
                first_len_r  <= len_s;
              end
            end else begin
              col_cnt_r <= sat_cnt(len_s);
            end
            if (bus.row_end) begin
              // matrix closed: restart per-matrix counters
              elem_cnt_r   <= '0;
              col_cnt_r    <= '0;
              row_cnt_r    <= '0;
              first_len_r  <= '0;
              first_done_r <= 1'b0;
              if (state_r == LOAD_B) begin
                b_rows_r <= row_nxt_s[DIM_W-1:0];
                b_cols_r <= cols_s;
                busy_r   <= 1'b1;
                state_r  <= CHECK;
              end else begin
                a_rows_r <= row_nxt_s[DIM_W-1:0];
                a_cols_r <= cols_s;
                state_r  <= LOAD_B;
              end
            end else if (state_r == IDLE) begin
              state_r <= LOAD_A;
            end
          end
        end

        CHECK: begin
          bad_r <= 1'b0;
          if (!bad_r && (a_cols_r == b_rows_r)) begin
            state_r     <= COMPUTE;
            i_r         <= '0;
            j_r         <= '0;
            k_r         <= '0;
            a_base_r    <= '0;
            rd_addr_a_r <= '0;
            rd_addr_b_r <= '0;
            mac_en_r    <= 1'b1;
            mac_clr_r   <= 1'b1;
            mac_last_r  <= (a_cols_r == D_ONE_C);
          end else begin
            state_r      <= REJECT;
            out_valid_r  <= 1'b1;
            is_legal_r   <= 1'b0;
            change_row_r <= 1'b0;
          end
        end

        REJECT: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end

        COMPUTE: begin
          if (!k_last_s) begin
            // next term of the same dot product
            k_r         <= k_r + D_ONE_C;
            rd_addr_a_r <= rd_addr_a_r + A_ONE_C;
            rd_addr_b_r <= rd_addr_b_r + ADDR_W'(b_cols_r);
            mac_clr_r   <= 1'b0;
            mac_last_r  <= ((k_r + D_ONE_C) == (a_cols_r - D_ONE_C));
          end else begin
            k_r        <= '0;
            mac_clr_r  <= 1'b1;
            mac_last_r <= (a_cols_r == D_ONE_C);
            if (!j_last_s) begin
              // next column of B, same row of A
              j_r         <= j_r + D_ONE_C;
              rd_addr_a_r <= a_base_r;
              rd_addr_b_r <= ADDR_W'(j_r + D_ONE_C);
            end else if (!i_last_s) begin
              // next row of A, first column of B
              j_r         <= '0;
              i_r         <= i_r + D_ONE_C;
              a_base_r    <= a_base_r + ADDR_W'(a_cols_r);
              rd_addr_a_r <= a_base_r + ADDR_W'(a_cols_r);
              rd_addr_b_r <= '0;
            end else begin
              // final term issued; wait for the datapath to flush
              j_r         <= '0;
              i_r         <= '0;
              state_r     <= DRAIN;
              drain_cnt_r <= '0;
              mac_en_r    <= 1'b0;
              mac_clr_r   <= 1'b0;
              mac_last_r  <= 1'b0;
              rd_addr_a_r <= '0;
              rd_addr_b_r <= '0;
            end
          end
        end

        DRAIN: begin
          if (drain_cnt_r == DRAIN_END_C) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            drain_cnt_r <= drain_cnt_r + B_ONE_C;
          end
        end

        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Scoreboard bench for mm_seq_ctrl. Stimulus pushes the expected writes,
// MAC terms, results and busy spans into queues; a negedge monitor acts
// as the operand buffers + MAC datapath and pops/compares whenever the
// DUT presents a write, a term, a result or the end of a busy span.
module tb_mm_seq_ctrl;
  localparam int DIM_W  = 4;
  localparam int ADDR_W = 8;
  localparam int PIPE   = 2;

  typedef struct {
    bit legal;
    bit crow;
    int val;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mm_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mm_seq_ctrl #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .PIPE(PIPE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  int   din    = 0;
  int   buf_a [256];
  int   buf_b [256];
  int   exp_wr_q [$];
  int   exp_mac_q [$];
  res_t exp_res_q [$];
  int   exp_busy_q [$];
  int   model_q [$];
  int   acc      = 0;
  int   busy_cnt = 0;
  int   prod;
  int   e_i;
  res_t r_e;
  logic [7:0] hist = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor + datapath model, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      acc      = 0;
      busy_cnt = 0;
      hist     = '0;
      model_q.delete();
    end else begin
      if (bus.wr_en) begin
        chk("wr_expected", int'(exp_wr_q.size() > 0), 1);
        if (exp_wr_q.size() > 0) begin
          e_i = exp_wr_q.pop_front();
          chk("wr_sel_addr", int'({bus.wr_sel, bus.wr_addr}), e_i);
        end
        if (bus.wr_sel) buf_b[bus.wr_addr] = din;
        else            buf_a[bus.wr_addr] = din;
      end
      if (bus.mac_en) begin
        chk("mac_expected", int'(exp_mac_q.size() > 0), 1);
        if (exp_mac_q.size() > 0) begin
          e_i = exp_mac_q.pop_front();
          chk("mac_term", int'({bus.rd_addr_a, bus.rd_addr_b, bus.mac_clr, bus.mac_last}), e_i);
        end
        prod = buf_a[bus.rd_addr_a] * buf_b[bus.rd_addr_b];
        acc  = bus.mac_clr ? prod : acc + prod;
        if (bus.mac_last) model_q.push_back(acc);
      end
      if (bus.out_valid) begin
        chk("res_expected", int'(exp_res_q.size() > 0), 1);
        if (exp_res_q.size() > 0) begin
          r_e = exp_res_q.pop_front();
          chk("is_legal", int'(bus.is_legal), int'(r_e.legal));
          chk("change_row", int'(bus.change_row), int'(r_e.crow));
          if (r_e.legal) begin
            chk("pipe_align", int'(hist[PIPE-1]), 1);
            chk("model_has_result", int'(model_q.size() > 0), 1);
            if (model_q.size() > 0) chk("result_value", model_q.pop_front(), r_e.val);
          end
        end
      end
      hist = {hist[6:0], bus.mac_en & bus.mac_last};
      if (bus.busy) begin
        busy_cnt++;
      end else if (busy_cnt > 0) begin
        chk("busy_expected", int'(exp_busy_q.size() > 0), 1);
        if (exp_busy_q.size() > 0) chk("busy_span", busy_cnt, exp_busy_q.pop_front());
        busy_cnt = 0;
      end
    end
  end

  // one stream element; returns one cycle later with in_valid dropped
  task automatic send(input int d, input bit ce, input bit re, input bit sel, input int addr);
    bus.in_valid = 1'b1;
    bus.col_end  = ce;
    bus.row_end  = re;
    din          = d;
    exp_wr_q.push_back(int'(sel) * 256 + addr);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.col_end  = 1'b0;
    bus.row_end  = 1'b0;
  endtask

  // whole matrix of consecutive values; gaps put idle cycles with stray delimiters
  task automatic load(input bit sel, input int rows, input int cols, input int first, input bit gaps);
    int n = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        send(first + n, (c == cols - 1), (r == rows - 1) && (c == cols - 1), sel, n);
        n++;
        if (gaps && !((r == rows - 1) && (c == cols - 1))) begin
          bus.col_end = 1'b1;
          bus.row_end = 1'b1;
          repeat (2) @(posedge clk);
          #1;
          bus.col_end = 1'b0;
          bus.row_end = 1'b0;
        end
      end
    end
  endtask

  // queue every expectation of a job, then stream A and B
  task automatic job(input int ar, input int ac, input int br, input int bc,
                     input int af, input int bf, input bit gaps,
                     input int r0, input int r1, input int r2, input int r3);
    int   rv [4];
    res_t r;
    rv[0] = r0; rv[1] = r1; rv[2] = r2; rv[3] = r3;
    if (ac == br) begin
      for (int i = 0; i < ar; i++) begin
        for (int j = 0; j < bc; j++) begin
          for (int k = 0; k < ac; k++) begin
            exp_mac_q.push_back(((i * ac + k) << 10) | ((k * bc + j) << 2) |
                                (int'(k == 0) << 1) | int'(k == ac - 1));
          end
          r.legal = 1'b1;
          r.crow  = (j == bc - 1);
          r.val   = rv[i * bc + j];
          exp_res_q.push_back(r);
        end
      end
      exp_busy_q.push_back(1 + ar * bc * ac + PIPE);
    end else begin
      r.legal = 1'b0;
      r.crow  = 1'b0;
      r.val   = 0;
      exp_res_q.push_back(r);
      exp_busy_q.push_back(2);
    end
    load(1'b0, ar, ac, af, gaps);
    load(1'b1, br, bc, bf, gaps);
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while ((bus.busy || exp_res_q.size() > 0) && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    chk("job_done_in_budget", int'(t < budget), 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, int'({bus.busy, bus.wr_en, bus.wr_sel, bus.mac_en, bus.mac_clr,
                             bus.mac_last, bus.out_valid, bus.is_legal, bus.change_row}), 0);
    chk({tag, "_addr"}, int'({bus.wr_addr, bus.rd_addr_a, bus.rd_addr_b}), 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.col_end  = 1'b0;
    bus.row_end  = 1'b0;
    #2 rst = 1'b0;
    #10;
    check_all_zero("reset_state");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 2x3 * 3x2 -> 58 64 / 139 154
    job(2, 3, 3, 2, 1, 7, 1'b0, 58, 64, 139, 154);
    wait_done(200);

    // 2x3 * 2x2 not conformable
    job(2, 3, 2, 2, 1, 7, 1'b0, 0, 0, 0, 0);
    wait_done(200);

    // 1x1 * 1x1 -> 35
    job(1, 1, 1, 1, 5, 7, 1'b0, 35, 0, 0, 0);
    wait_done(200);

    // 1x4 * 4x1 -> 70, with stray stream input while busy
    job(1, 4, 4, 1, 1, 5, 1'b0, 70, 0, 0, 0);
    bus.in_valid = 1'b1;
    bus.col_end  = 1'b1;
    bus.row_end  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.col_end  = 1'b0;
    bus.row_end  = 1'b0;
    wait_done(200);

    // reset during COMPUTE of the 2x3 * 3x2 job
    job(2, 3, 3, 2, 1, 7, 1'b0, 58, 64, 139, 154);
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b0;
    exp_wr_q.delete();
    exp_mac_q.delete();
    exp_res_q.delete();
    exp_busy_q.delete();
    #1;
    check_all_zero("abort");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    // 1x1 * 1x1 -> 18 after the abort
    job(1, 1, 1, 1, 2, 9, 1'b0, 18, 0, 0, 0);
    wait_done(200);

    // back-to-back jobs with idle gaps in the stream
    job(2, 2, 2, 2, 1, 5, 1'b1, 19, 22, 43, 50);
    wait_done(200);
    job(1, 2, 2, 1, 1, 3, 1'b1, 11, 0, 0, 0);
    wait_done(200);

    repeat (4) @(posedge clk);
    #1;
    chk("queues_drained", exp_wr_q.size() + exp_mac_q.size() + exp_res_q.size() + exp_busy_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
